muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have no parameters; datapath width is fixed at 32 bits.
REQ-002 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port: op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port: a  input  32  rs operand (register-file rd1 after forwarding).
REQ-007 SHALL have port: b  input  32  rt operand (register-file rd2 after forwarding).
REQ-008 SHALL have port: flush  input  1  abort any in-flight operation.
REQ-009 SHALL have port: hi_we, lo_we  input  1 each  MTHI/MTLO write strobes.
REQ-010 SHALL have port: wd  input  32  MTHI/MTLO write data.
REQ-011 SHALL have port: busy  output  1  operation in flight; drives hazard-unit stall.
REQ-012 SHALL have port: done  output  1  one-cycle pulse; hi/lo hold the new result.
REQ-013 SHALL have port: hi, lo  output  32 each  architectural HI/LO registers (MFHI/MFLO source).

Function
REQ-014 SHALL implement FSM states IDLE, RUN, FIX, DONE; busy=1 in RUN and FIX only.
REQ-015 SHALL, in IDLE with start=1 at edge k, latch op, |a| and |b| (signed ops) or raw a and b (unsigned ops), and the sign flags, clear a 6-bit iteration counter, and enter RUN.
REQ-016 SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per RUN cycle, for exactly 32 cycles (edges k+1..k+32), then enter FIX.
REQ-017 SHALL, in FIX, apply sign correction and write hi/lo at edge k+33, then enter DONE; done=1 for the cycle after edge k+33 only; DONE returns to IDLE on the next edge.
REQ-018 SHALL use the following multiply result format: {hi,lo} = 64-bit product; the product is negated when signed and sign(a)^sign(b)=1.
REQ-019 SHALL use the following divide result format: lo = quotient, hi = remainder; for signed ops the quotient is negated if sign(a)^sign(b)=1 and the remainder takes the sign of a.
REQ-020 SHALL produce lo=0x80000000, hi=0 for signed 0x80000000 / 0xFFFFFFFF, with no exception.
REQ-021 SHALL handle divide by zero (b=0) with the normal latency, giving lo=0xFFFFFFFF and hi=a.
REQ-022 SHALL ignore start when not in IDLE.
REQ-023 SHALL return to IDLE on flush=1 at any edge; hi/lo are left unchanged and done is not asserted; flush outranks start in the same cycle.
REQ-024 SHALL apply hi_we/lo_we (hi<=wd / lo<=wd) only in IDLE or DONE; the strobes are ignored while busy=1.
REQ-025 SHALL, when start and hi_we/lo_we coincide in IDLE, apply the write and accept the start; the later result overwrites HI/LO.
REQ-026 SHALL register all outputs; there is no combinational path from inputs to busy, done, hi or lo.

Reset
REQ-027 SHALL, on reset=1 at a rising edge, set state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
REQ-028 SHALL abort any in-flight operation when reset is asserted, with no done pulse.
REQ-029 SHALL give reset priority over flush, start and the write strobes.

Configuration
REQ-030 SHALL support the macro MULDIV_DIV_EN: when defined, divide ops behave as specified above.
REQ-031 SHALL, when MULDIV_DIV_EN is undefined, omit the divider datapath; DIV/DIVU starts go IDLE->DONE (done one cycle after acceptance, busy never set) and hi/lo are unchanged.

Verification
REQ-032 SHALL cover: MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done 34 cycles after start, hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 SHALL cover: MULT a=-3 (0xFFFFFFFD) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles.
REQ-034 SHALL cover: DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=100.
REQ-035 SHALL cover: flush at cycle 10 of a MULTU -> busy=0 next cycle, no done pulse, hi/lo keep their prior values; a new start next cycle completes normally.
REQ-036 SHALL cover: hi_we with wd=0x1234 while busy -> ignored; same write in IDLE -> hi=0x1234 next cycle.
REQ-037 SHALL cover: reset mid-RUN -> all outputs 0 next cycle; with MULDIV_DIV_EN undefined, a DIV start -> done after 1 cycle and hi/lo unchanged.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MIPS-style multiply/divide unit that owns the HI/LO registers.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise DIV/DIVU complete at once as no-ops.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wd,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state_q;
    logic        busy_q, done_q;
    logic [31:0] hi_q, lo_q;
    logic [5:0]  cnt_q;
    logic [31:0] m_q, acc_q, q_q;
    logic        neg_q;

    logic        sgn;
    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum;
    logic [63:0] prod;

    assign sgn   = ~op[0];
    assign abs_a = (sgn && a[31]) ? -a : a;
    assign abs_b = (sgn && b[31]) ? -b : b;

    // {acc,q} shifts right each step; the low bit of q selects whether m is added in.
    assign mul_sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : 33'd0);
    assign prod    = neg_q ? -{acc_q, q_q} : {acc_q, q_q};

`ifdef MULDIV_DIV_EN
    logic        is_div_q, neg_r_q, bz_q;
    logic [32:0] div_sh;
    logic [31:0] div_sub, quo_fix, rem_fix;
    logic        div_ge;

    assign div_sh  = {acc_q, q_q[31]};
    assign div_ge  = div_sh >= {1'b0, m_q};
    assign div_sub = div_sh[31:0] - m_q;
    // A zero divisor leaves all-ones quotient and the dividend as remainder; keep that quotient unsigned.
    assign quo_fix = (neg_q && !bz_q) ? -q_q : q_q;
    assign rem_fix = neg_r_q ? -acc_q : acc_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            cnt_q   <= 6'd0;
            m_q     <= 32'd0;
            acc_q   <= 32'd0;
            q_q     <= 32'd0;
            neg_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q <= 1'b0;
            neg_r_q  <= 1'b0;
            bz_q     <= 1'b0;
`endif
        end else if (flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    if (hi_we) hi_q <= wd;
                    if (lo_we) lo_q <= wd;
                    if (state_q == IDLE && start) begin
                        acc_q <= 32'd0;
                        cnt_q <= 6'd0;
                        neg_q <= sgn & (a[31] ^ b[31]);
`ifdef MULDIV_DIV_EN
                        is_div_q <= op[1];
                        neg_r_q  <= sgn & a[31];
                        bz_q     <= (b == 32'd0);
                        m_q      <= op[1] ? abs_b : abs_a;
                        q_q      <= op[1] ? abs_a : abs_b;
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
`else
                        m_q <= abs_a;
                        q_q <= abs_b;
                        if (op[1]) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
`endif
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + 6'd1;
`ifdef MULDIV_DIV_EN
                    if (is_div_q) begin
                        acc_q <= div_ge ? div_sub : div_sh[31:0];
                        q_q   <= {q_q[30:0], div_ge};
                    end else begin
                        acc_q <= mul_sum[32:1];
                        q_q   <= {mul_sum[0], q_q[31:1]};
                    end
`else
                    acc_q <= mul_sum[32:1];
                    q_q   <= {mul_sum[0], q_q[31:1]};
`endif
                    if (cnt_q == 6'd31) state_q <= FIX;
                end
                FIX: begin
`ifdef MULDIV_DIV_EN
                    if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod[63:32];
                        lo_q <= prod[31:0];
                    end
`else
                    hi_q <= prod[63:32];
                    lo_q <= prod[31:0];
`endif
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: constant vector table, randomized ops against an arithmetic model,
// and hand-written flush / reset / HI-LO write sequences.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset, start, flush, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wd;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;
    vec_t tv[$];

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Returns {hi, lo} as the architecture defines it; ph/pl are the current HI/LO.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] ph, input logic [31:0] pl);
        int     sx, sy, q, r;
        longint p;
        sx = x;
        sy = y;
        case (o)
            2'b00: begin
                p = longint'(sx) * longint'(sy);
                return 64'(p);
            end
            2'b01: return {32'd0, x} * {32'd0, y};
            default: begin
                if (!DIV_EN) return {ph, pl};
                if (y == 32'd0) return {x, 32'hFFFFFFFF};
                if (o == 2'b11) return {x % y, x / y};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                q = sx / sy;
                r = sx % sy;
                return {r, q};
            end
        endcase
    endfunction

    task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] exp, input bit mt);
        int n = 0;
        int nb = 0;
        bit seen = 1'b0;
        int elat;
        elat = (o[1] && !DIV_EN) ? 1 : 34;
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        if (mt) begin hi_we = 1'b1; lo_we = 1'b1; wd = 32'h5A5A5A5A; end
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (done) seen = 1'b1;
        end
        chk({nm, ".latency"}, 64'(n), 64'(elat));
        chk({nm, ".busycyc"}, 64'(nb), 64'(elat == 34 ? 33 : 0));
        chk({nm, ".hi"}, 64'(hi), 64'(exp[63:32]));
        chk({nm, ".lo"}, 64'(lo), 64'(exp[31:0]));
        @(negedge clk);
        chk({nm, ".donepulse"}, 64'(done), 64'd0);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen, anyd;
        int          n;
        logic [1:0]  o;
        logic [31:0] x, y;
        logic [63:0] e;

        reset = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; a = 32'd0; b = 32'd0; wd = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.hi", 64'(hi), 64'd0);
        chk("rst.lo", 64'(lo), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        tv.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
        tv.push_back('{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB});
        tv.push_back('{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
        tv.push_back('{2'b01, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000});
        tv.push_back('{2'b00, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9});
        tv.push_back('{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000});
        tv.push_back('{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
        tv.push_back('{2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF});
        tv.push_back('{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
        tv.push_back('{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
        tv.push_back('{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF});
        tv.push_back('{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF});
        for (int i = 0; i < tv.size(); i++) begin
            e = (tv[i].op[1] && !DIV_EN) ? {m_hi, m_lo} : {tv[i].ehi, tv[i].elo};
            do_op($sformatf("vec%0d", i), tv[i].op, tv[i].a, tv[i].b, e, 1'b0);
        end

        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 5) == 0) y = 32'($urandom_range(1, 20));
            do_op($sformatf("rand%0d", i), o, x, y, model(o, x, y, m_hi, m_lo), 1'b0);
        end

        // start and MTHI/MTLO in the same IDLE cycle: the product must win
        do_op("mtstart", 2'b01, 32'h00001000, 32'h00000003, 64'h0000000000003000, 1'b1);

        // write strobe and a second start while busy are both ignored
        @(posedge clk); #1;
        start = 1'b1; op = 2'b01; a = 32'h00012345; b = 32'h00000010;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        hi_we = 1'b1; wd = 32'h00001234; start = 1'b1; op = 2'b11; a = 32'd5; b = 32'd0;
        @(posedge clk); #1;
        hi_we = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("busywr.hi_hold", 64'(hi), 64'(m_hi));
        seen = 1'b0; n = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
        chk("busywr.done", 64'(seen), 64'd1);
        chk("busywr.hi", 64'(hi), 64'd0);
        chk("busywr.lo", 64'(lo), 64'h00123450);
        m_hi = 32'd0; m_lo = 32'h00123450;
        @(posedge clk); #1;
        hi_we = 1'b1; wd = 32'h00001234;
        @(posedge clk); #1;
        hi_we = 1'b0;
        @(negedge clk);
        chk("idlewr.hi", 64'(hi), 64'h1234);
        chk("idlewr.lo", 64'(lo), 64'(m_lo));
        m_hi = 32'h00001234;
        @(posedge clk); #1;
        lo_we = 1'b1; wd = 32'hCAFEF00D;
        @(posedge clk); #1;
        lo_we = 1'b0;
        @(negedge clk);
        chk("idlewr.lo2", 64'(lo), 64'hCAFEF00D);
        m_lo = 32'hCAFEF00D;

        // flush ten cycles into a MULTU, then restart immediately
        @(posedge clk); #1;
        start = 1'b1; op = 2'b01; a = 32'h0000FFFF; b = 32'h0000FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("flush.busy", 64'(busy), 64'd0);
        chk("flush.done", 64'(done), 64'd0);
        chk("flush.hi", 64'(hi), 64'(m_hi));
        chk("flush.lo", 64'(lo), 64'(m_lo));
        do_op("postflush", 2'b01, 32'h0000FFFF, 32'h0000FFFF, 64'h00000000FFFE0001, 1'b0);

        // reset in the middle of RUN
        @(posedge clk); #1;
        start = 1'b1; op = 2'b00; a = 32'hFFFFFFFD; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst.busy", 64'(busy), 64'd0);
        chk("midrst.done", 64'(done), 64'd0);
        chk("midrst.hi", 64'(hi), 64'd0);
        chk("midrst.lo", 64'(lo), 64'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        anyd = 1'b0;
        repeat (40) begin
            @(negedge clk);
            anyd = anyd | done | busy;
        end
        chk("midrst.quiet", 64'(anyd), 64'd0);
        do_op("postrst", 2'b00, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFFFFFFFFEB, 1'b0);
        do_op("postrst_div", 2'b10, 32'hFFFFFFF9, 32'd2, model(2'b10, 32'hFFFFFFF9, 32'd2, m_hi, m_lo), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
